// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 responder (SR/Cause/EPC/PrID), hw interrupt sync and gating; optional timer via CP0_TIMER_EN
module cp0_unit #(
    parameter logic [31:0] PRID        = 32'h0000_0330,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] pc_in,
    input  logic [31:0] din,
    input  logic [4:0]  sel,
    input  logic        we,
    input  logic        exl_set,
    input  logic        exl_clr,
    input  logic [5:0]  hw_int,
    output logic [31:0] dout,
    output logic [31:0] epc,
    output logic        int_req
);
    logic [SYNC_STAGES*6-1:0] r_sync;
    logic [5:0]  r_ip;
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [29:0] r_epc;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [5:0]  w_ip;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_wr_sr;
    logic        w_wr_epc;
    assign w_wr_sr  = we && sel == 5'd12;
    assign w_wr_epc = we && sel == 5'd14;
    // synchroniser chain per hw_int line, IP resampled from the last stage every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_ip   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES*6-7:0], hw_int};
            r_ip   <= r_sync[SYNC_STAGES*6-1 -: 6];
        end
    end
    // SR/EPC state; exception entry outranks ERET and MTC0 for EXL and EPC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im  <= '0;
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_epc <= '0;
        end else begin
            if (w_wr_sr) begin
                r_im <= din[15:10];
                r_ie <= din[0];
            end
            if (exl_set)      r_exl <= 1'b1;
            else if (exl_clr) r_exl <= 1'b0;
            else if (w_wr_sr) r_exl <= din[1];
            if (exl_set)       r_epc <= pc_in;
            else if (w_wr_epc) r_epc <= din[31:2];
        end
    end
`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    // free-running Count; TI latches on a match and is cleared only by rewriting Compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_count <= (we && sel == 5'd9) ? din : r_count + 32'd1;
            if (we && sel == 5'd11) begin
                r_compare <= din;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'd0) begin
                r_ti <= 1'b1;
            end
        end
    end
    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = '0;
    assign w_compare = '0;
`endif
    assign w_ip    = r_ip | {w_ti, 5'b0};
    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {1'b0, w_ti, 14'b0, w_ip, 10'b0};
    assign epc     = {r_epc, 2'b00};
    assign int_req = r_ie & ~r_exl & |(w_ip & r_im);
    // MFC0 read mux; unimplemented numbers read zero
    always_comb begin
        case (sel)
            5'd9:    dout = w_count;
            5'd11:   dout = w_compare;
            5'd12:   dout = w_sr;
            5'd13:   dout = w_cause;
            5'd14:   dout = epc;
            5'd15:   dout = PRID;
            default: dout = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit with a behavioural CP0 model (timer modelled when CP0_TIMER_EN)
module tb_cp0_unit;
    localparam int SS = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] pc_in = '0;
    logic [31:0] din = '0;
    logic [4:0]  sel = '0;
    logic        we = 1'b0;
    logic        exl_set = 1'b0;
    logic        exl_clr = 1'b0;
    logic [5:0]  hw_int = '0;
    logic [31:0] dout;
    logic [31:0] epc;
    logic        int_req;

    cp0_unit #(.PRID(32'h0000_0330), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .din(din), .sel(sel), .we(we),
        .exl_set(exl_set), .exl_clr(exl_clr), .hw_int(hw_int),
        .dout(dout), .epc(epc), .int_req(int_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] epc;
        logic        irq;
        logic [4:0]  sel;
    } exp_t;
    exp_t q[$];
    int n_pass = 0;
    int n_chk = 0;

    // behavioural model
    logic [5:0]  m_im;
    logic        m_ie;
    logic        m_exl;
    logic [31:0] m_epc;
    logic [5:0]  m_ip;
    logic [5:0]  m_line[$];
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_ti;

    task automatic model_reset();
        m_im = 0; m_ie = 0; m_exl = 0; m_epc = 0; m_ip = 0;
        m_cnt = 0; m_cmp = 0; m_ti = 0;
        m_line.delete();
        for (int i = 0; i < SS; i++) m_line.push_back(6'd0);
    endtask

    function automatic logic [5:0] m_ip_eff();
        return m_ip | (m_ti ? 6'h20 : 6'h00);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] s);
        logic [31:0] v;
        v = 0;
        if (s == 12) v = (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
        if (s == 13) v = (32'(m_ip_eff()) << 10) + (32'(m_ti) << 30);
        if (s == 14) v = m_epc;
        if (s == 15) v = 32'h0000_0330;
`ifdef CP0_TIMER_EN
        if (s == 9)  v = m_cnt;
        if (s == 11) v = m_cmp;
`endif
        return v;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_line.push_back(hw_int);
        m_ip = m_line.pop_front();
`ifdef CP0_TIMER_EN
        if (we && sel == 11) begin
            m_cmp = din;
            m_ti = 0;
        end else if (m_cnt == m_cmp && m_cmp != 0) m_ti = 1;
        m_cnt = (we && sel == 9) ? din : m_cnt + 1;
`endif
        if (we && sel == 12) begin
            m_im = din[15:10];
            m_ie = din[0];
            m_exl = din[1];
        end
        if (we && sel == 14) m_epc = din & 32'hFFFF_FFFC;
        if (exl_clr) m_exl = 0;
        if (exl_set) begin
            m_exl = 1;
            m_epc = {pc_in, 2'b00};
        end
    endtask

    // apply inputs just after an edge, queue what the DUT must show this cycle, then advance one edge
    task automatic step(input logic w, input logic [4:0] s, input logic [31:0] d,
                        input logic es, input logic ec, input logic [29:0] pc, input logic [5:0] h);
        exp_t e;
        we = w; sel = s; din = d; exl_set = es; exl_clr = ec; pc_in = pc; hw_int = h;
        if (!rst_n) model_reset();
        e.dout = m_read(s);
        e.epc  = m_epc;
        e.irq  = m_ie & ~m_exl & |(m_ip_eff() & m_im);
        e.sel  = s;
        q.push_back(e);
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic rd(input logic [4:0] s, input logic [5:0] h);
        step(0, s, 0, 0, 0, 0, h);
    endtask

    // monitor: one observation per cycle at mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk += 3;
                if (dout === e.dout) n_pass++;
                else $display("FAIL dout sel=%0d got %h want %h at %0t", e.sel, dout, e.dout, $time);
                if (epc === e.epc) n_pass++;
                else $display("FAIL epc got %h want %h at %0t", epc, e.epc, $time);
                if (int_req === e.irq) n_pass++;
                else $display("FAIL int_req got %b want %b at %0t", int_req, e.irq, $time);
            end
        end
    end

    initial begin
        logic [4:0] sels[7];
        logic [5:0] h;
        logic [4:0] s;
        logic [31:0] d;
        sels = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        model_reset();
        @(posedge clk);
        #1;
        // reset state
        rd(12, 0); rd(13, 0); rd(14, 0); rd(15, 0);
        rst_n = 1'b1;
        rd(12, 0); rd(15, 0);
        // interrupt rise/fall latency
        step(1, 12, 32'h0000_0401, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) rd(13, 6'h01);
        for (int i = 0; i < 4; i++) rd(12, 6'h00);
        for (int i = 0; i < 4; i++) rd(13, 6'h01);
        // exception entry and ERET
        step(0, 12, 0, 1, 0, 30'h0000_0C01, 6'h01);
        rd(12, 6'h01); rd(14, 6'h01);
        step(0, 12, 0, 0, 1, 0, 6'h01);
        rd(12, 6'h01);
        // simultaneous exl_set and EPC write; set beats clr
        step(1, 14, 32'hDEAD_BEEF, 1, 1, 30'h10, 6'h01);
        rd(14, 6'h01); rd(12, 6'h01);
        step(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 6'h01);
        rd(13, 6'h01);
        // clr with SR write: EXL must end 0 even though din[1]=1
        step(1, 12, 32'h0000_0403, 0, 1, 0, 6'h01);
        rd(12, 6'h01);
        // set with SR write: EXL ends 1
        step(1, 12, 32'h0000_0401, 1, 0, 30'h3FFF_FFFF, 6'h01);
        rd(12, 6'h01);
        step(0, 12, 0, 0, 1, 0, 6'h00);
        // masked or disabled source
        step(1, 12, 32'h0000_0401, 0, 0, 0, 6'h04);
        for (int i = 0; i < 4; i++) rd(13, 6'h04);
        step(1, 12, 32'h0000_1000, 0, 0, 0, 6'h04);
        for (int i = 0; i < 3; i++) rd(13, 6'h04);
        step(1, 12, 32'h0000_1001, 0, 0, 0, 6'h04);
        rd(12, 6'h04); rd(13, 6'h00);
        // timer (reads 0 and stays quiet when not built in)
        step(1, 12, 32'h0000_8001, 0, 0, 0, 6'h00);
        step(1, 11, 32'd5, 0, 0, 0, 6'h00);
        step(1, 9, 32'd0, 0, 0, 0, 6'h00);
        for (int i = 0; i < 9; i++) rd((i % 2) ? 5'd13 : 5'd9, 6'h00);
        step(1, 11, 32'd100, 0, 0, 0, 6'h00);
        rd(13, 0); rd(11, 0); rd(9, 0);
        step(1, 3, 32'hFFFF_FFFF, 0, 0, 0, 6'h00);
        rd(3, 0);
        // randomized traffic
        h = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) h = 6'($urandom);
            s = sels[$urandom_range(0, 6)];
            if (s == 7) s = 5'($urandom);
            d = $urandom;
            if (s == 12 && $urandom_range(0, 1) == 1) d = d & 32'hFFFF_FFFD | 32'h1;
            if (s == 9 || s == 11) d = $urandom_range(0, 24);
            step($urandom_range(0, 3) == 0, s, d, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0, 30'($urandom), h);
        end
        // async reset in mid-operation drops int_req before any edge
        step(0, 12, 0, 0, 1, 0, 6'h00);
        step(1, 12, 32'h0000_0401, 0, 0, 0, 6'h01);
        for (int i = 0; i < 4; i++) rd(12, 6'h01);
        rst_n = 1'b0;
        rd(12, 6'h01);
        rd(14, 6'h01);
        rst_n = 1'b1;
        rd(12, 6'h01); rd(13, 6'h01);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
